fmul_norm_pipe: RTL and testbench

Back end of the single-precision multiplier. It consumes the mul-stage bundle: sign, 10-bit biased exponent, special-case flags, NaN fraction and the Wallace-tree sum/carry/z8. It completes the carry-propagate add, then normalizes (including denormal results), rounds and packs the IEEE-754 result. It is a 2-stage valid/ready pipeline, so a multi-cycle FPU issue path can stall it without dropping operations.

---
 rtl/fmul_norm_pipe.sv | 159 +++++++++++++++
 tb/tb_fmul_norm_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_norm_pipe.sv
// FP32 multiplier back end: carry-propagate add, normalize/denormalize, round, pack.
// Two-stage valid/ready pipeline; `define FMUL_FLAGS_EN adds the fflags output.
module fmul_norm_pipe #(
    parameter int EXP_W     = 10,
    parameter int SHIFT_CAP = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       rm,
    input  logic             sign,
    input  logic [EXP_W-1:0] exp10,
    input  logic             s_is_nan,
    input  logic             s_is_inf,
    input  logic [22:0]      inf_nan_frac,
    input  logic [39:0]      z_sum,
    input  logic [39:0]      z_carry,
    input  logic [7:0]       z8,
`ifdef FMUL_FLAGS_EN
    output logic [4:0]       fflags,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result
);
    localparam int EW = EXP_W + 3;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [31:0]             result_q, result_d;
    logic [47:0]             z48_q;
    logic signed [EXP_W-1:0] exp_q;
    logic                    sign_q, nan_q, inf_q;
    logic [1:0]              rm_q;
    logic [22:0]             frac_q;
    logic                    advance2, in_fire;

    assign advance2  = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | advance2;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_valid_q;
    assign result    = result_q;

    always_ff @(posedge clk) begin
        if (in_fire) begin
            z48_q  <= {z_sum + z_carry, z8};
            exp_q  <= exp10;
            sign_q <= sign;
            rm_q   <= rm;
            nan_q  <= s_is_nan;
            inf_q  <= s_is_inf;
            frac_q <= inf_nan_frac;
        end
    end

    logic signed [EW-1:0] lz, e0, lsh, e1, rsh, e2, e3;
    logic [47:0]          m1, m2;
    logic                 dsticky, g, st, inc, ovf, to_inf, zero;
    logic [23:0]          kept, mant;
    logic [24:0]          rsum;
    logic [31:0]          packed_res;

    // m is read as 1.xxx * 2^(e-127) with the binary point below m[47];
    // e == 1 with m[47] clear is the denormal scale.
    always_comb begin
        lz = EW'(48);
        for (int i = 0; i < 48; i++) begin
            if (z48_q[i]) lz = EW'(47 - i);
        end
        e0  = EW'(exp_q) + EW'(1);
        lsh = '0;
        if (e0 > EW'(1)) lsh = ((e0 - EW'(1)) < lz) ? (e0 - EW'(1)) : lz;
        m1 = z48_q << lsh[5:0];
        e1 = e0 - lsh;

        rsh     = '0;
        m2      = m1;
        dsticky = 1'b0;
        e2      = e1;
        if (e1 < EW'(1)) begin
            rsh = EW'(1) - e1;
            if (rsh > EW'(SHIFT_CAP)) rsh = EW'(SHIFT_CAP);
            m2      = m1 >> rsh[5:0];
            dsticky = |(m1 & ~({48{1'b1}} << rsh[5:0]));
            e2      = EW'(1);
        end

        kept = m2[47:24];
        g    = m2[23];
        st   = (|m2[22:0]) | dsticky;
        inc  = 1'b0;
        case (rm_q)
            2'b00:   inc = g & (st | kept[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = sign_q & (g | st);
            default: inc = ~sign_q & (g | st);
        endcase

        rsum = {1'b0, kept} + 25'(inc);
        mant = rsum[23:0];
        e3   = e2;
        if (rsum[24]) begin
            mant = 24'h800000;
            e3   = e2 + EW'(1);
        end

        ovf    = mant[23] & (e3 > EW'(254));
        to_inf = (rm_q == 2'b00) | ((rm_q == 2'b10) & sign_q) | ((rm_q == 2'b11) & ~sign_q);
        zero   = (z48_q == 48'h0);

        if (nan_q)       packed_res = {sign_q, 8'hff, frac_q};
        else if (inf_q)  packed_res = {sign_q, 8'hff, 23'h0};
        else if (zero)   packed_res = {sign_q, 31'h0};
        else if (ovf)    packed_res = to_inf ? {sign_q, 8'hff, 23'h0} : {sign_q, 8'hfe, 23'h7fffff};
        else             packed_res = {sign_q, mant[23] ? e3[7:0] : 8'h00, mant[22:0]};
    end

    always_comb begin
        s1_valid_d = in_fire | (s1_valid_q & ~advance2);
        s2_valid_d = advance2 ? s1_valid_q : s2_valid_q;
        result_d   = (advance2 & s1_valid_q) ? packed_res : result_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= 32'h0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
        end
    end

`ifdef FMUL_FLAGS_EN
    // The bundle carries no signalling-NaN marker, so every NaN result raises NV.
    logic [4:0] fflags_q, fflags_d;
    logic       regular;

    always_comb begin
        regular  = ~nan_q & ~inf_q & ~zero;
        fflags_d = fflags_q;
        if (advance2 & s1_valid_q) begin
            fflags_d = {nan_q, 1'b0, regular & ovf,
                        regular & ~m2[47] & (g | st),
                        regular & (g | st | ovf)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fflags_q <= 5'h0;
        else     fflags_q <= fflags_d;
    end

    assign fflags = fflags_q;
`endif
endmodule

// File: tb/tb_fmul_norm_pipe.sv
// Bench for fmul_norm_pipe: upstream mul-stage model drives bundles, an exact-arithmetic
// IEEE rounding model fills a scoreboard that a separate monitor drains.
module tb_fmul_norm_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sign, s_is_nan, s_is_inf, out_valid, out_ready;
    logic [1:0]  rm;
    logic [9:0]  exp10;
    logic [22:0] inf_nan_frac;
    logic [39:0] z_sum, z_carry;
    logic [7:0]  z8;
    logic [31:0] result;

    typedef struct packed {
        logic        sgn;
        logic [9:0]  e10;
        logic        nan;
        logic        inf;
        logic [22:0] frac;
        logic [39:0] zs;
        logic [39:0] zc;
        logic [7:0]  zl;
    } bnd_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    bit          bp_en = 0;
    bit          hold_prev = 0;
    logic [31:0] prev_res;

    fmul_norm_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .rm(rm),
        .sign(sign), .exp10(exp10), .s_is_nan(s_is_nan), .s_is_inf(s_is_inf),
        .inf_nan_frac(inf_nan_frac), .z_sum(z_sum), .z_carry(z_carry), .z8(z8),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Upstream multiplier stage: exact significand product split into a random sum/carry pair.
    function automatic bnd_t mk_bundle(input logic [31:0] a, input logic [31:0] b);
        bnd_t        bd;
        logic [23:0] ma, mb;
        logic [47:0] p;
        int          ea, eb;
        bit          anan, bnan, ainf, binf, azero, bzero;
        ma = {a[30:23] != 0, a[22:0]};
        mb = {b[30:23] != 0, b[22:0]};
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        anan  = (a[30:23] == 8'hff) && (a[22:0] != 0);
        bnan  = (b[30:23] == 8'hff) && (b[22:0] != 0);
        ainf  = (a[30:23] == 8'hff) && (a[22:0] == 0);
        binf  = (b[30:23] == 8'hff) && (b[22:0] == 0);
        azero = (a[30:0] == 0);
        bzero = (b[30:0] == 0);
        p = 48'(ma) * 48'(mb);
        bd.sgn  = a[31] ^ b[31];
        bd.e10  = 10'(ea + eb - 127);
        bd.nan  = 1'b0;
        bd.inf  = 1'b0;
        bd.frac = 23'h0;
        if (anan || bnan) begin
            bd.nan  = 1'b1;
            bd.sgn  = 1'b0;
            bd.frac = (anan ? a[22:0] : b[22:0]) | 23'h400000;
        end else if ((ainf && bzero) || (binf && azero)) begin
            bd.nan  = 1'b1;
            bd.sgn  = 1'b0;
            bd.frac = 23'h400000;
        end else if (ainf || binf) begin
            bd.inf = 1'b1;
        end
        bd.zs = 40'({$urandom(), $urandom()});
        bd.zc = p[47:8] - bd.zs;
        bd.zl = p[7:0];
        return bd;
    endfunction

    // Value = p * 2^e, rounded to FP32 in mode rmode with unbounded exponent, then packed.
    function automatic logic [31:0] ref_round(input logic s, input logic [47:0] p,
                                              input int e, input logic [1:0] rmode);
        int          msb, x, q, sh, field;
        logic [63:0] kept, rem, half;
        bit          up, nz, gt, eq;
        if (p == 0) return {s, 31'h0};
        msb = 0;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        x  = msb + e;
        q  = (x - 23 > -149) ? x - 23 : -149;
        sh = q - e;
        nz = 0; gt = 0; eq = 0;
        if (sh <= 0) begin
            kept = 64'(p) << (-sh);
        end else if (sh > 48) begin
            kept = 64'h0;
            nz   = 1;
        end else begin
            kept = 64'(p) >> sh;
            rem  = 64'(p) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            nz   = (rem != 0);
            gt   = (rem > half);
            eq   = (rem == half);
        end
        case (rmode)
            2'b00:   up = gt || (eq && kept[0]);
            2'b01:   up = 0;
            2'b10:   up = s && nz;
            default: up = !s && nz;
        endcase
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            q++;
        end
        if (kept < (64'd1 << 23)) return {s, 8'h00, kept[22:0]};
        field = q + 150;
        if (field >= 255) begin
            if (rmode == 2'b00 || (rmode == 2'b10 && s) || (rmode == 2'b11 && !s))
                return {s, 8'hff, 23'h0};
            return {s, 8'hfe, 23'h7fffff};
        end
        return {s, 8'(field), kept[22:0]};
    endfunction

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] r);
        logic [23:0] ma, mb;
        int          ea, eb;
        ma = {a[30:23] != 0, a[22:0]};
        mb = {b[30:23] != 0, b[22:0]};
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        return ref_round(a[31] ^ b[31], 48'(ma) * 48'(mb), ea + eb - 300, r);
    endfunction

    function automatic logic [31:0] rnd_fp(input int e);
        return {1'($urandom()), 8'(e), 23'($urandom())};
    endfunction

    task automatic apply(input bnd_t bd, input logic [1:0] r);
        sign = bd.sgn; exp10 = bd.e10; s_is_nan = bd.nan; s_is_inf = bd.inf;
        inf_nan_frac = bd.frac; z_sum = bd.zs; z_carry = bd.zc; z8 = bd.zl; rm = r;
    endtask

    // Returns just after the edge that transfers the op.
    task automatic send(input bnd_t bd, input logic [1:0] r, input logic [31:0] expv);
        int guard = 0;
        @(negedge clk);
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        apply(bd, r);
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            guard++;
            if (guard > 200) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_test(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] r, input logic [31:0] expv);
        send(mk_bundle(a, b), r, expv);
        #1 check("lat_after_edge1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 check("lat_after_edge2", 32'(out_valid), 32'd1);
    endtask

    // Monitor: looks mid-low-phase, after the driver has settled this cycle's inputs.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", result, prev_res);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_output: got %h, expected no output", result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_res  = result;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    logic [31:0] dir_a[10] = '{32'h3FC00000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h00000001,
                               32'h00000001, 32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h80000001};
    logic [31:0] dir_b[10] = '{32'h3FC00000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000,
                               32'h3F000000, 32'h00000000, 32'h40000000, 32'hBF800000, 32'h3F000000};
    logic [1:0]  dir_r[10] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2};
    logic [31:0] dir_e[10] = '{32'h40100000, 32'h7F800000, 32'h7F7FFFFF, 32'h00400000, 32'h00000000,
                               32'h00000001, 32'h7FC00000, 32'hFF800000, 32'hBF800000, 32'h80000001};

    initial begin
        logic [31:0] a, b;
        logic [1:0]  r;
        int          ea, eb, guard;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        apply(mk_bundle(32'h0, 32'h0), 2'd0);
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("reset_in_ready", 32'(in_ready), 32'd1);

        lat_test(dir_a[0], dir_b[0], dir_r[0], dir_e[0]);
        for (int i = 1; i < 10; i++) send(mk_bundle(dir_a[i], dir_b[i]), dir_r[i], dir_e[i]);

        // Stall: two accepted, third held off, results held, then drained in order.
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = rnd_fp($urandom_range(100, 150)); b = rnd_fp($urandom_range(100, 150));
            send(mk_bundle(a, b), 2'd0, ref_op(a, b, 2'd0));
        end
        a = rnd_fp($urandom_range(100, 150)); b = rnd_fp($urandom_range(100, 150));
        @(negedge clk);
        apply(mk_bundle(a, b), 2'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd1);
        exp_q.push_back(ref_op(a, b, 2'd0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("drain_second", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 check("drain_third", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 check("drain_empty", 32'(out_valid), 32'd0);

        // Reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = rnd_fp($urandom_range(100, 150)); b = rnd_fp($urandom_range(100, 150));
            send(mk_bundle(a, b), 2'd0, ref_op(a, b, 2'd0));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 check("postrst_out_valid", 32'(out_valid), 32'd0);
        lat_test(dir_a[0], dir_b[0], dir_r[0], dir_e[0]);

        // Randomized traffic with random backpressure.
        bp_en = 1;
        for (int k = 0; k < 400; k++) begin
            ea = $urandom_range(0, 254);
            case ($urandom_range(0, 3))
                1:       eb = 97 - ea + int'($urandom_range(0, 40));
                2:       eb = 378 - ea + int'($urandom_range(0, 6));
                default: eb = $urandom_range(0, 254);
            endcase
            if (eb < 0) eb = 0;
            if (eb > 254) eb = 254;
            a = rnd_fp(ea);
            b = rnd_fp(eb);
            if ($urandom_range(0, 15) == 0) a = {a[31], 31'h0};
            if ($urandom_range(0, 7) == 0) b[22:0] = 23'h0;
            r = 2'($urandom());
            send(mk_bundle(a, b), r, ref_op(a, b, r));
        end
        bp_en = 0;
        @(negedge clk);
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
